pipe_ctrl: RTL and testbench

Parametrised pipeline sequencer for the in-order lc3b CPU datapath. It generates the PC load, the load enable for every inter-stage pipe register, and a registered valid bit for each pipe register, for a configurable stage count. It adds behaviour the current datapath lacks: fetch and data-memory wait stalls, load-use bubble insertion, taken-branch flush and saturating performance counters. It sits beside the datapath and replaces the free-running `load_*` / `*_v` registers.

---
 rtl/pipe_ctrl_if.sv | 38 +++
 rtl/pipe_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: datapath <-> sequencer bundle.
// master = datapath side, slave = pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 16
);
  logic                    i_mem_resp;
  logic                    d_mem_access;
  logic                    d_mem_resp;
  logic                    hazard;
  logic                    br_taken;
  logic                    clr_cnt;
  logic                    load_pc;
  logic                    pcmux_sel;
  logic [NUM_STAGES-2:0]   load_pipe;
  logic [NUM_STAGES-2:0]   valid;
  logic                    flush;
  logic                    retire;
  logic [CNT_W-1:0]        stall_cnt;
  logic [CNT_W-1:0]        flush_cnt;
  logic [CNT_W-1:0]        retire_cnt;

  modport master (
    output i_mem_resp, d_mem_access, d_mem_resp,
    output hazard, br_taken, clr_cnt,
    input  load_pc, pcmux_sel, load_pipe, valid,
    input  flush, retire,
    input  stall_cnt, flush_cnt, retire_cnt
  );

  modport slave (
    input  i_mem_resp, d_mem_access, d_mem_resp,
    input  hazard, br_taken, clr_cnt,
    output load_pc, pcmux_sel, load_pipe, valid,
    output flush, retire,
    output stall_cnt, flush_cnt, retire_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline sequencer with stalls,
// load-use bubbles, branch flush and perf counters.
module pipe_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int DEC_STAGE  = 1,
  parameter int BR_STAGE   = 3,
  parameter int MEM_STAGE  = 3,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  pipe_ctrl_if.slave  bus
);
  localparam int N = NUM_STAGES - 1;

  localparam logic [N-1:0] ALL  = '1;
  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [N-1:0] MEM_HOLD = N'((1 << MEM_STAGE) - 1);
  localparam logic [N-1:0] DEC_HOLD = N'((1 << DEC_STAGE) - 1);
  localparam logic [N-1:0] BR_MASK  = N'((1 << BR_STAGE) - 1);

  logic [N-1:0] v;
  logic [N-1:0] v_nxt;
  logic [N-1:0] adv;
  logic [N-1:0] hold_m;
  logic [N-1:0] bub_m;
  logic         dstall, hz, istall, br;
  logic         sel_d, sel_h, sel_i;
  logic         frozen, flush;

  logic [CNT_W-1:0] stall_q, flush_q, retire_q;

  assign dstall = v[MEM_STAGE-1] & bus.d_mem_access
                & ~bus.d_mem_resp;
  assign hz     = v[DEC_STAGE-1] & bus.hazard;
  assign istall = ~bus.i_mem_resp;
  assign br     = v[BR_STAGE-1] & bus.br_taken;

  // Exclusive freeze selects in priority order.
  assign sel_d  = dstall;
  assign sel_h  = hz & ~dstall;
  assign sel_i  = istall & ~dstall & ~hz;
  assign frozen = sel_d | sel_h | sel_i;

  // A dstall freeze sits at or past the branch stage,
  // so it defers the branch; other freezes lose to it.
  assign flush = ~reset & br & ~sel_d;

  assign adv = {v[N-2:0], 1'b1};

  // Hold mask (regs before F) and bubble mask (reg F).
  always_comb begin
    hold_m = '0;
    bub_m  = '0;
    unique case (1'b1)
      sel_d: begin
        hold_m = MEM_HOLD;
        bub_m  = ONE << MEM_STAGE;
      end
      sel_h: begin
        hold_m = DEC_HOLD;
        bub_m  = ONE << DEC_STAGE;
      end
      sel_i: begin
        bub_m  = ONE;
      end
      default: ;
    endcase
  end

  // Next valid vector: flush squashes younger regs.
  always_comb begin
    if (flush)
      v_nxt = adv & ~BR_MASK;
    else
      v_nxt = (v & hold_m) | (adv & ~hold_m & ~bub_m);
  end

  // Valid bits and saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      v        <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
      retire_q <= '0;
    end else begin
      v <= v_nxt;
      if (bus.clr_cnt)
        stall_q <= '0;
      else if (frozen & ~flush & ~&stall_q)
        stall_q <= stall_q + 1'b1;
      if (bus.clr_cnt)
        flush_q <= '0;
      else if (flush & ~&flush_q)
        flush_q <= flush_q + 1'b1;
      if (bus.clr_cnt)
        retire_q <= '0;
      else if (v[N-1] & ~&retire_q)
        retire_q <= retire_q + 1'b1;
    end
  end

  assign bus.load_pc    = ~reset & (flush | ~frozen);
  assign bus.pcmux_sel  = flush;
  assign bus.load_pipe  = reset ? '0 :
                          flush ? ALL : ~hold_m;
  assign bus.valid      = v;
  assign bus.flush      = flush;
  assign bus.retire     = v[N-1];
  assign bus.stall_cnt  = stall_q;
  assign bus.flush_cnt  = flush_q;
  assign bus.retire_cnt = retire_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: random stimulus against a slot-array
// model of the pipeline; 4-bit counters hit saturation.
module tb_pipe_ctrl;
  localparam int NS  = 5;
  localparam int N   = NS - 1;
  localparam int DEC = 1;
  localparam int BR  = 3;
  localparam int MEM = 3;
  localparam int CW  = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;

  pipe_ctrl_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

  pipe_ctrl #(
    .NUM_STAGES(NS), .DEC_STAGE(DEC), .BR_STAGE(BR),
    .MEM_STAGE(MEM), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  // Reference state: which pipe slots hold a live instr.
  bit m_v[N];
  int m_sc, m_fc, m_rc;

  function automatic int sat(input int c, input bit inc,
                             input bit clr);
    if (clr) return 0;
    if (inc && c < MAXC) return c + 1;
    return c;
  endfunction

  task automatic step(input bit rst, input bit imr,
                      input bit acc, input bit dresp,
                      input bit hzd, input bit brt,
                      input bit clr);
    int f;
    bit fl, dst, hzq, brq;
    bit nv[N];
    logic [N-1:0] e_lp, e_v;
    reset            = rst;
    bus.i_mem_resp   = imr;
    bus.d_mem_access = acc;
    bus.d_mem_resp   = dresp;
    bus.hazard       = hzd;
    bus.br_taken     = brt;
    bus.clr_cnt      = clr;
    #1;
    dst = m_v[MEM-1] && acc && !dresp;
    hzq = m_v[DEC-1] && hzd;
    brq = m_v[BR-1] && brt;
    f = dst ? MEM : hzq ? DEC : !imr ? 0 : -1;
    fl = !rst && brq && (f < 0 || f < BR);
    for (int k = 0; k < N; k++) begin
      e_v[k]  = m_v[k];
      e_lp[k] = !rst && (fl || f < 0 || k >= f);
    end
    chk("valid",   32'(bus.valid), 32'(e_v));
    chk("load_pipe", 32'(bus.load_pipe), 32'(e_lp));
    chk("load_pc", 32'(bus.load_pc),
        32'(!rst && (fl || f < 0)));
    chk("flush",   32'(bus.flush), 32'(fl));
    if (!rst)
      chk("pcmux_sel", 32'(bus.pcmux_sel), 32'(fl));
    chk("retire",  32'(bus.retire), 32'(m_v[N-1]));
    chk("stall_cnt",  32'(bus.stall_cnt),  32'(m_sc));
    chk("flush_cnt",  32'(bus.flush_cnt),  32'(m_fc));
    chk("retire_cnt", 32'(bus.retire_cnt), 32'(m_rc));
    // Move instructions through the slot array.
    for (int k = N - 1; k >= 0; k--) begin
      if (rst)
        nv[k] = 0;
      else if (fl)
        nv[k] = (k < BR) ? 0 : m_v[k-1];
      else if (f < 0 || k > f)
        nv[k] = (k == 0) ? 1'b1 : m_v[k-1];
      else if (k == f)
        nv[k] = 0;
      else
        nv[k] = m_v[k];
    end
    if (rst) begin
      m_sc = 0; m_fc = 0; m_rc = 0;
    end else begin
      m_sc = sat(m_sc, f >= 0 && !fl, clr);
      m_fc = sat(m_fc, fl, clr);
      m_rc = sat(m_rc, m_v[N-1], clr);
    end
    m_v = nv;
    @(negedge clk);
  endtask

  initial begin
    bit r;
    foreach (m_v[k]) m_v[k] = 0;
    m_sc = 0; m_fc = 0; m_rc = 0;
    reset = 1'b1;
    bus.i_mem_resp = 1'b0;
    bus.d_mem_access = 1'b0;
    bus.d_mem_resp = 1'b0;
    bus.hazard = 1'b0;
    bus.br_taken = 1'b0;
    bus.clr_cnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Fill from empty, then retire into saturation.
    for (int i = 0; i < 24; i++)
      step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1);
    // Load-use and flush-over-hazard directed cases.
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0, 1, 0);
    step(0, 1, 1, 1, 0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) < 2);
      step(r,
           $urandom_range(0, 99) < 75,
           $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 3);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
